// File: rtl/encoder4_2_rr.sv
// encoder4_2_rr: round-robin 4:2 encoder with pending-request capture,
// valid/ready issue handshake and duplicate-request flag.
module encoder4_2_rr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       ready,
  output logic [1:0] y,
  output logic       valid,
  output logic [3:0] pend,
  output logic       dup
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] ptr;
  logic [1:0] ptr_nx;
  logic [1:0] y_nx;
  logic       valid_nx;
  logic [1:0] sel;
  logic [1:0] off;
  logic [7:0] dbl;
  logic [3:0] rot;
  logic [3:0] clr;
  logic [3:0] pend_nx;
  logic       dup_nx;
  logic       any;
  logic       load;

  // Rotate pend so bit 0 is the ptr slot; first set bit wins.
  always_comb begin
    dbl = {pend, pend};
    rot = dbl[ptr +: 4];
    any = |pend;
    off = 2'd0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
    sel = ptr + off;
  end

  // Next state, issue load, pending update and duplicate detect.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    y_nx     = y;
    valid_nx = valid;
    ptr_nx   = ptr;
    unique case (state)
      IDLE: begin
        if (any) load = 1'b1;
      end
      HOLD: begin
        if (ready) begin
          if (any) begin
            load = 1'b1;
          end else begin
            valid_nx = 1'b0;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (load) begin
      y_nx     = sel;
      valid_nx = 1'b1;
      state_nx = HOLD;
      ptr_nx   = sel + 2'd1;
    end
    clr     = load ? (4'b0001 << sel) : 4'b0000;
    pend_nx = (pend & ~clr) | (en ? req : 4'b0000);
    dup_nx  = en & (|(req & pend & ~clr));
  end

  // State, outputs and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      y     <= 2'd0;
      valid <= 1'b0;
      pend  <= 4'b0000;
      dup   <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      y     <= y_nx;
      valid <= valid_nx;
      pend  <= pend_nx;
      dup   <= dup_nx;
    end
  end

endmodule

// File: tb/tb_encoder4_2_rr.sv
// tb_encoder4_2_rr: directed scenarios plus random traffic checked
// against a behavioural round-robin reference model.
module tb_encoder4_2_rr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0;
  logic       ready = 1'b0;
  logic [1:0] y;
  logic       valid;
  logic [3:0] pend;
  logic       dup;

  int checks = 0;
  int errors = 0;

  bit m_pend [4];
  int m_y;
  int m_ptr;
  bit m_valid;
  bit m_dup;

  encoder4_2_rr dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req),
    .ready (ready),
    .y     (y),
    .valid (valid),
    .pend  (pend),
    .dup   (dup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_pend_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pend[i] = 0;
    m_y = 0;
    m_ptr = 0;
    m_valid = 0;
    m_dup = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_y"}, {30'd0, y}, m_y);
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, m_valid});
    chk({tag, "_pend"}, {28'd0, pend}, {28'd0, m_pend_vec()});
    chk({tag, "_dup"}, {31'd0, dup}, {31'd0, m_dup});
  endtask

  // One clock: the model consumes the inputs present before the edge.
  task automatic step(input string tag);
    int  pick;
    bit  any;
    bit  issue;
    bit  nxt [4];
    bit  d;
    pick = -1;
    any = 0;
    for (int i = 0; i < 4; i++) if (m_pend[i]) any = 1;
    for (int k = 0; k < 4; k++)
      if (pick < 0 && m_pend[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
    issue = any && (!m_valid || ready);
    d = 0;
    for (int i = 0; i < 4; i++) begin
      bit cleared;
      bit r;
      cleared = issue && (pick == i);
      r = en && req[i];
      nxt[i] = (m_pend[i] && !cleared) || r;
      if (r && m_pend[i] && !cleared) d = 1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) m_pend[i] = nxt[i];
    m_dup = d;
    if (issue) begin
      m_y = pick;
      m_valid = 1;
      m_ptr = (pick + 1) % 4;
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset_async");
    @(posedge clk);
    #1;
    check_all("reset_held");
    rst_n = 1'b1;

    // single request
    en = 1; req = 4'b0100; ready = 1;
    step("single_cap");
    en = 0; req = 0;
    step("single_load");
    chk("single_y", {30'd0, y}, 2);
    chk("single_v", {31'd0, valid}, 1);
    step("single_done");
    chk("single_v0", {31'd0, valid}, 0);
    chk("single_p0", {28'd0, pend}, 0);

    // fairness: ptr is now 3
    en = 1; req = 4'b0101;
    step("fair_cap");
    en = 0; req = 0;
    step("fair_a");
    chk("fair_first", {30'd0, y}, 0);
    step("fair_b");
    chk("fair_second", {30'd0, y}, 2);
    step("fair_done");

    // serve index 3 so the burst starts at ptr 0
    en = 1; req = 4'b1000;
    step("align_cap");
    en = 0; req = 0;
    step("align_load");
    step("align_done");

    // burst
    en = 1; req = 4'b1111;
    step("burst_cap");
    en = 0; req = 0;
    for (int i = 0; i < 4; i++) begin
      step("burst");
      chk("burst_y", {30'd0, y}, i);
      chk("burst_v", {31'd0, valid}, 1);
    end
    step("burst_done");
    chk("burst_end_v", {31'd0, valid}, 0);

    // backpressure (ptr back at 0)
    en = 1; req = 4'b0011; ready = 0;
    step("bp_cap");
    en = 0; req = 0;
    for (int i = 0; i < 5; i++) begin
      step("bp_hold");
      chk("bp_y", {30'd0, y}, 0);
      chk("bp_v", {31'd0, valid}, 1);
    end
    ready = 1;
    step("bp_next");
    chk("bp_y1", {30'd0, y}, 1);
    step("bp_done");
    chk("bp_v0", {31'd0, valid}, 0);

    // duplicate merge
    en = 1; req = 4'b0011; ready = 0;
    step("dup_cap");
    en = 0; req = 0;
    step("dup_load");
    chk("dup_pend1", {31'd0, pend[1]}, 1);
    en = 1; req = 4'b0010;
    step("dup_again");
    chk("dup_pulse", {31'd0, dup}, 1);
    en = 0; req = 0;
    step("dup_fall");
    chk("dup_low", {31'd0, dup}, 0);
    ready = 1;
    step("dup_issue");
    chk("dup_y1", {30'd0, y}, 1);
    step("dup_done");
    chk("dup_once", {31'd0, valid}, 0);

    // enable gating
    en = 0; req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step("gate");
      chk("gate_pend", {28'd0, pend}, 0);
      chk("gate_v", {31'd0, valid}, 0);
    end

    // reset mid-burst
    en = 1; req = 4'b1111; ready = 1;
    step("rst_cap");
    en = 0; req = 0;
    step("rst_load");
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_all("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      en = ($urandom % 4) != 0;
      req = 4'($urandom);
      ready = ($urandom % 3) != 0;
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
